// File: rtl/nor_logic_sequencer.sv
// -----------------------------------------------------------------------------
// nor_logic_sequencer
//
// Multi-pass controller that time-shares one external WIDTH-bit bitwise NOR
// unit to compute NOR, OR, AND, NAND, XOR, XNOR and NOTA. One NOR pass is
// issued per RUN cycle. Intermediate values are kept in the temps t1..t3, and
// the final value is returned over a valid/ready response channel.
//
// Handshakes (both channels): a transfer happens on a rising clk edge where
// valid && ready are both high. The request side is ready only in IDLE. The
// response side holds resp_valid, resp_result and resp_err stable until the
// consumer takes the result with resp_ready.
//
// Parameters
//   WIDTH       operand/result width, also the width of the shared NOR unit
//   ERR_VALUE   result returned for the illegal opcode 3'b111
//
// Ports
//   clk, rst_n               clock (rising edge), asynchronous active-low reset
//   req_valid / req_ready    request handshake (req_ready high only in IDLE)
//   req_op, req_a, req_b     opcode and operands, captured on acceptance
//   nor_a, nor_b, nor_r      shared NOR unit (nor_r is combinational)
//   resp_valid / resp_ready  response handshake
//   resp_result, resp_err    final value and illegal-opcode flag
//   busy                     high whenever the FSM is not in IDLE
//   perf_passes              (only with NOR_SEQ_PERF_CNT_EN) count of RUN cycles
//
// Configuration macro: NOR_SEQ_PERF_CNT_EN adds the perf_passes counter port.
// -----------------------------------------------------------------------------
module nor_logic_sequencer #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] ERR_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [WIDTH-1:0] nor_a,
  output logic [WIDTH-1:0] nor_b,
  input  logic [WIDTH-1:0] nor_r,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_err,
`ifdef NOR_SEQ_PERF_CNT_EN
  output logic [31:0]      perf_passes,
`endif
  output logic             busy
);

  localparam logic [2:0] OP_NOR  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_NAND = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_NOTA = 3'b110;
  localparam logic [2:0] OP_ILL  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Where the NOR output of the current pass is written.
  typedef enum logic [1:0] {
    D_T1 = 2'd0,
    D_T2 = 2'd1,
    D_T3 = 2'd2,
    D_R  = 2'd3
  } dest_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] t1_q, t2_q, t3_q;
  logic [2:0]       pass_q;
  logic             err_settle_q;
  dest_t            dest;
  logic             accept;
  logic             last_pass;

  assign accept    = req_valid && req_ready;
  assign last_pass = (state_q == S_RUN) && (dest == D_R);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = (req_op == OP_ILL) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (last_pass) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (resp_valid && resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: handshake flags and the NOR pass table
  // ---------------------------------------------------------------------------
  // req_ready is gated by rst_n so that every output reads 0 while reset is
  // asserted; it rises as soon as reset is released.
  assign req_ready = (state_q == S_IDLE) && rst_n;
  assign busy      = (state_q != S_IDLE);
  // An illegal opcode enters DONE straight from IDLE, but its response is held
  // back for one cycle so it appears one edge after acceptance.
  assign resp_valid = (state_q == S_DONE) && !err_settle_q;

  always_comb begin
    nor_a = '0;
    nor_b = '0;
    dest  = D_R;
    if (state_q == S_RUN) begin
      case (op_q)
        OP_NOR: begin
          nor_a = a_q; nor_b = b_q; dest = D_R;
        end
        OP_NOTA: begin
          nor_a = a_q; nor_b = a_q; dest = D_R;
        end
        OP_OR: begin
          case (pass_q)
            3'd0:    begin nor_a = a_q;  nor_b = b_q;  dest = D_T1; end
            default: begin nor_a = t1_q; nor_b = t1_q; dest = D_R;  end
          endcase
        end
        OP_AND, OP_NAND: begin
          // AND ends at pass 2; NAND parks that value in t3 and inverts it.
          case (pass_q)
            3'd0: begin nor_a = a_q; nor_b = a_q; dest = D_T1; end
            3'd1: begin nor_a = b_q; nor_b = b_q; dest = D_T2; end
            3'd2: begin
              nor_a = t1_q;
              nor_b = t2_q;
              dest  = (op_q == OP_AND) ? D_R : D_T3;
            end
            default: begin nor_a = t3_q; nor_b = t3_q; dest = D_R; end
          endcase
        end
        OP_XNOR, OP_XOR: begin
          // XNOR ends at pass 3; XOR parks that value in t3 and inverts it.
          case (pass_q)
            3'd0: begin nor_a = a_q; nor_b = b_q;  dest = D_T1; end
            3'd1: begin nor_a = a_q; nor_b = t1_q; dest = D_T2; end
            3'd2: begin nor_a = b_q; nor_b = t1_q; dest = D_T3; end
            3'd3: begin
              nor_a = t2_q;
              nor_b = t3_q;
              dest  = (op_q == OP_XNOR) ? D_R : D_T3;
            end
            default: begin nor_a = t3_q; nor_b = t3_q; dest = D_R; end
          endcase
        end
        default: begin
          // Illegal opcodes never enter RUN; finish at once if one ever does.
          dest = D_R;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers: captured request, temps, pass index, response
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q         <= 3'b000;
      a_q          <= '0;
      b_q          <= '0;
      t1_q         <= '0;
      t2_q         <= '0;
      t3_q         <= '0;
      pass_q       <= 3'd0;
      resp_result  <= '0;
      resp_err     <= 1'b0;
      err_settle_q <= 1'b0;
    end else begin
      err_settle_q <= accept && (req_op == OP_ILL);
      if (accept) begin
        op_q   <= req_op;
        a_q    <= req_a;
        b_q    <= req_b;
        pass_q <= 3'd0;
        if (req_op == OP_ILL) begin
          resp_result <= ERR_VALUE;
          resp_err    <= 1'b1;
        end
      end else if (state_q == S_RUN) begin
        pass_q <= pass_q + 3'd1;
        case (dest)
          D_T1: t1_q <= nor_r;
          D_T2: t2_q <= nor_r;
          D_T3: t3_q <= nor_r;
          default: begin
            resp_result <= nor_r;
            resp_err    <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef NOR_SEQ_PERF_CNT_EN
  // Free-running count of NOR passes issued; wraps naturally at 32 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_passes <= 32'd0;
    end else if (state_q == S_RUN) begin
      perf_passes <= perf_passes + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_nor_logic_sequencer.sv
// -----------------------------------------------------------------------------
// tb_nor_logic_sequencer
//
// Directed bench for nor_logic_sequencer. A behavioural NOR unit closes the
// loop on nor_a/nor_b/nor_r. Each operation is issued through run_op, which
// checks per-cycle latency, the first pass operands, the result, optional
// backpressure behaviour and the return to IDLE. Expected results are
// hand-computed constants.
// -----------------------------------------------------------------------------
module tb_nor_logic_sequencer;

  localparam int WIDTH = 32;

  localparam logic [2:0] OP_NOR  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_NAND = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_NOTA = 3'b110;
  localparam logic [2:0] OP_ILL  = 3'b111;

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT
  // ---------------------------------------------------------------------------
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [2:0]       req_op = 3'b000;
  logic [WIDTH-1:0] req_a = '0;
  logic [WIDTH-1:0] req_b = '0;
  logic [WIDTH-1:0] nor_a, nor_b, nor_r;
  logic             resp_valid;
  logic             resp_ready = 1'b0;
  logic [WIDTH-1:0] resp_result;
  logic             resp_err;
  logic             busy;
`ifdef NOR_SEQ_PERF_CNT_EN
  logic [31:0]      perf_passes;
`endif

  always #5 clk = ~clk;

  // Shared NOR unit model.
  assign nor_r = ~(nor_a | nor_b);

  nor_logic_sequencer #(
    .WIDTH     (WIDTH),
    .ERR_VALUE ('0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .nor_a       (nor_a),
    .nor_b       (nor_b),
    .nor_r       (nor_r),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .resp_err    (resp_err),
`ifdef NOR_SEQ_PERF_CNT_EN
    .perf_passes (perf_passes),
`endif
    .busy        (busy)
  );

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver: issue one op, follow it to completion and the response handshake.
  //   n     : edges from acceptance to resp_valid
  //   na0/nb0: expected NOR operands during the first cycle after acceptance
  //   hold  : cycles of response backpressure, with a competing request offered
  // Called with time sitting 1 time unit after a rising edge.
  // ---------------------------------------------------------------------------
  task automatic run_op(input string name, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b, input int n,
                        input logic [31:0] exp_r, input logic exp_e,
                        input logic [31:0] na0, input logic [31:0] nb0,
                        input int hold);
    check({name, "_req_ready_idle"}, req_ready, 1);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    @(posedge clk); #1;
    // Scramble the request inputs: captured values must be unaffected.
    req_valid = 1'b0;
    req_op    = OP_NOR;
    req_a     = ~a;
    req_b     = a ^ b ^ 32'h5A5A_A5A5;
    check({name, "_valid_after_accept"}, resp_valid, 0);
    check({name, "_busy_after_accept"}, busy, 1);
    check({name, "_req_ready_busy"}, req_ready, 0);
    check({name, "_nor_a_pass0"}, nor_a, na0);
    check({name, "_nor_b_pass0"}, nor_b, nb0);
    for (int i = 1; i < n; i++) begin
      @(posedge clk); #1;
      check({name, "_valid_early"}, resp_valid, 0);
    end
    @(posedge clk); #1;
    check({name, "_valid"}, resp_valid, 1);
    check({name, "_result"}, resp_result, exp_r);
    check({name, "_err"}, resp_err, exp_e);
    check({name, "_nor_a_idle"}, nor_a, 0);
    check({name, "_nor_b_idle"}, nor_b, 0);
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      req_op    = OP_NOTA;
      req_a     = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      check({name, "_bp_valid"}, resp_valid, 1);
      check({name, "_bp_result"}, resp_result, exp_r);
      check({name, "_bp_req_ready"}, req_ready, 0);
      check({name, "_bp_busy"}, busy, 1);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check({name, "_valid_cleared"}, resp_valid, 0);
    check({name, "_busy_cleared"}, busy, 0);
    check({name, "_req_ready_back"}, req_ready, 1);
  endtask

  // Safety net: the bench must always end by itself.
  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  initial begin
    // Reset state while rst_n is low.
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_nor_a", nor_a, 0);
    check("rst_nor_b", nor_b, 0);
    check("rst_result", resp_result, 0);
    check("rst_err", resp_err, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_req_ready", req_ready, 1);
    check("post_rst_busy", busy, 0);
`ifdef NOR_SEQ_PERF_CNT_EN
    check("post_rst_perf", perf_passes, 0);
`endif

    // Main function, one per opcode.
    run_op("and",  OP_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 3, 32'hF000_F000, 1'b0,
           32'hF0F0_F0F0, 32'hF0F0_F0F0, 0);
    run_op("xor",  OP_XOR,  32'h1234_5678, 32'hFFFF_0000, 5, 32'hEDCB_5678, 1'b0,
           32'h1234_5678, 32'hFFFF_0000, 0);
    run_op("xnor", OP_XNOR, 32'h1234_5678, 32'hFFFF_0000, 4, 32'h1234_A987, 1'b0,
           32'h1234_5678, 32'hFFFF_0000, 0);
    run_op("nor",  OP_NOR,  32'h0000_0000, 32'h0000_0000, 1, 32'hFFFF_FFFF, 1'b0,
           32'h0000_0000, 32'h0000_0000, 0);
    run_op("nota", OP_NOTA, 32'h0000_FFFF, 32'h1357_9BDF, 1, 32'hFFFF_0000, 1'b0,
           32'h0000_FFFF, 32'h0000_FFFF, 0);
    run_op("or",   OP_OR,   32'h0F0F_0000, 32'h00FF_00FF, 2, 32'h0FFF_00FF, 1'b0,
           32'h0F0F_0000, 32'h00FF_00FF, 0);
    run_op("nand", OP_NAND, 32'hF0F0_F0F0, 32'hFF00_FF00, 4, 32'h0FFF_0FFF, 1'b0,
           32'hF0F0_F0F0, 32'hF0F0_F0F0, 0);

    // Backpressure: response held 3 cycles while a new request is offered.
    run_op("bp_and", OP_AND, 32'hAAAA_5555, 32'hFFFF_0F0F, 3, 32'hAAAA_0505, 1'b0,
           32'hAAAA_5555, 32'hAAAA_5555, 3);

    // Illegal opcode: error response one edge after accept, NOR unit idle.
    run_op("ill",  OP_ILL,  32'h1111_2222, 32'h3333_4444, 1, 32'h0000_0000, 1'b1,
           32'h0000_0000, 32'h0000_0000, 0);

    // Legal op after an error clears resp_err.
    run_op("nor2", OP_NOR,  32'h00FF_0F0F, 32'h0F00_00F0, 1, 32'hF000_F000, 1'b0,
           32'h00FF_0F0F, 32'h0F00_00F0, 0);

    // Reset in the middle of an XOR (during its second pass).
    req_valid = 1'b1;
    req_op    = OP_XOR;
    req_a     = 32'h1234_5678;
    req_b     = 32'hFFFF_0000;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("midrst_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_resp_valid", resp_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_req_ready", req_ready, 0);
    check("midrst_nor_a", nor_a, 0);
    check("midrst_nor_b", nor_b, 0);
    check("midrst_result", resp_result, 0);
    check("midrst_err", resp_err, 0);
`ifdef NOR_SEQ_PERF_CNT_EN
    check("midrst_perf", perf_passes, 0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("midrst_no_stale_valid", resp_valid, 0);
    end
    check("midrst_idle_busy", busy, 0);
    run_op("post_rst_xnor", OP_XNOR, 32'hFFFF_FFFF, 32'h0F0F_F0F0, 4, 32'h0F0F_F0F0, 1'b0,
           32'hFFFF_FFFF, 32'h0F0F_F0F0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
